mem_read_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_read_arbiter_rr_picker.sv | 54 +++++
 rtl/mem_read_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_mem_read_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory read arbiter.
// Arbitration policy selected by the READ_ARB_RR_EN macro (see rr_picker).
package mem_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_t;

  localparam int ARB_ID_W = 4;

  // Increment an index modulo n (used for the round-robin pointer).
  function automatic int wrap_inc(input int v, input int n);
    return ((v + 1) >= n) ? 0 : (v + 1);
  endfunction

endpackage

// File: rtl/mem_read_arbiter_rr_picker.sv
// Request picker: one-hot grant plus index from a request vector.
// With READ_ARB_RR_EN defined the search starts at ptr (round-robin);
// otherwise the lowest requesting index wins and no pointer port exists.
module rr_picker #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
`ifdef READ_ARB_RR_EN
  input  logic [IDX_W-1:0] ptr,
`endif
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

`ifdef READ_ARB_RR_EN
  // Rotating search: first requester at or after the pointer wins.
  always_comb begin
    logic [IDX_W-1:0] j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = '0;
    for (int off = 0; off < N; off++) begin
      j = IDX_W'((int'(ptr) + off) % N);
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end else begin
        any = any;
      end
    end
  end
`else
  // Fixed priority: lowest requesting index wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any && req[i]) begin
        any      = 1'b1;
        grant[i] = 1'b1;
        idx      = IDX_W'(i);
      end else begin
        any = any;
      end
    end
  end
`endif

endmodule

// File: rtl/mem_read_arbiter.sv
// N-master AXI read-channel arbiter with bounded outstanding bursts.
// AR winners are registered onto the downstream port tagged with the
// master index; R beats are routed back combinationally by s_rid.
// Define READ_ARB_RR_EN for round-robin arbitration (fixed priority otherwise).
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module mem_read_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_MASTERS     = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ADDR_W          = `ADDR_WIDTH,
  parameter int DATA_W          = `DATA_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_MASTERS-1:0]          m_arvalid,
  output logic [NUM_MASTERS-1:0]          m_arready,
  input  logic [4*NUM_MASTERS-1:0]        m_arlen,
  input  logic [ADDR_W*NUM_MASTERS-1:0]   m_araddr,
  output logic [NUM_MASTERS-1:0]          m_rvalid,
  output logic [NUM_MASTERS-1:0]          m_rlast,
  input  logic [NUM_MASTERS-1:0]          m_rready,
  output logic [DATA_W-1:0]               m_rdata,
  output logic                            s_arvalid,
  input  logic                            s_arready,
  output logic [ARB_ID_W-1:0]             s_arid,
  output logic [3:0]                      s_arlen,
  output logic [ADDR_W-1:0]               s_araddr,
  input  logic                            s_rvalid,
  input  logic                            s_rlast,
  input  logic [ARB_ID_W-1:0]             s_rid,
  input  logic [DATA_W-1:0]               s_rdata,
  output logic                            s_rready,
  output logic                            rid_err
);

  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef logic [IDX_W-1:0] master_idx_t;

  arb_state_t             state;
  logic [CNT_W-1:0]       out_cnt;
  logic [NUM_MASTERS-1:0] pick_grant;
  master_idx_t            pick_idx;
  logic                   pick_any;
  logic                   grant_en;
  logic                   ar_done;
  logic                   r_done;
  logic                   rid_ok;
  logic [3:0]             sel_len;
  logic [ADDR_W-1:0]      sel_addr;

`ifdef READ_ARB_RR_EN
  master_idx_t            rr_ptr;
`endif

  rr_picker #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_picker (
    .req   (m_arvalid),
`ifdef READ_ARB_RR_EN
    .ptr   (rr_ptr),
`endif
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Grant only from IDLE with room for another burst; held off while in reset.
  assign grant_en  = rst_n && (state == IDLE) && (out_cnt < CNT_W'(MAX_OUTSTANDING)) && pick_any;
  assign m_arready = grant_en ? pick_grant : '0;
  assign ar_done   = (state == ISSUE) && s_arready;
  // Late beats of abandoned bursts must not push the count below zero.
  assign r_done    = s_rvalid && s_rready && s_rlast && (out_cnt != '0);
  assign m_rdata   = s_rdata;

  // Select the winning master's burst length and address.
  always_comb begin
    sel_len  = 4'd0;
    sel_addr = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        sel_len  = m_arlen[i*4 +: 4];
        sel_addr = m_araddr[i*ADDR_W +: ADDR_W];
      end else begin
        sel_len  = sel_len;
      end
    end
  end

  // Route the R beat to the lane named by s_rid; unknown IDs are sunk.
  always_comb begin
    m_rvalid = '0;
    m_rlast  = '0;
    s_rready = 1'b1;
    rid_ok   = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (s_rid == ARB_ID_W'(i)) begin
        rid_ok      = 1'b1;
        m_rvalid[i] = s_rvalid;
        m_rlast[i]  = s_rlast;
        s_rready    = m_rready[i];
      end else begin
        rid_ok = rid_ok;
      end
    end
  end

  // AR state machine: capture the winner, then hold it on the downstream port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      s_arvalid <= 1'b0;
      s_arid    <= 4'd0;
      s_arlen   <= 4'd0;
      s_araddr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_en) begin
            state     <= ISSUE;
            s_arvalid <= 1'b1;
            s_arid    <= ARB_ID_W'(pick_idx);
            s_arlen   <= sel_len;
            s_araddr  <= sel_addr;
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          if (s_arready) begin
            state     <= IDLE;
            s_arvalid <= 1'b0;
          end else begin
            state <= ISSUE;
          end
        end
        default: begin
          state     <= IDLE;
          s_arvalid <= 1'b0;
        end
      endcase
    end
  end

  // Outstanding burst count: +1 on AR handshake, -1 on a completed last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt <= '0;
    end else begin
      case ({ar_done, r_done})
        2'b10:   out_cnt <= out_cnt + CNT_W'(1);
        2'b01:   out_cnt <= out_cnt - CNT_W'(1);
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  // Sticky flag for beats carrying an ID with no matching master.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rid_err <= 1'b0;
    end else if (s_rvalid && !rid_ok) begin
      rid_err <= 1'b1;
    end else begin
      rid_err <= rid_err;
    end
  end

`ifdef READ_ARB_RR_EN
  // Round-robin pointer moves just past each granted master.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (grant_en) begin
      rr_ptr <= master_idx_t'(wrap_inc(int'(pick_idx), NUM_MASTERS));
    end else begin
      rr_ptr <= rr_ptr;
    end
  end
`endif

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Self-checking bench for mem_read_arbiter (3 masters, 2 outstanding).
// Directed scenarios followed by a randomized phase, all compared against
// a transaction-level model of the arbitration and routing rules.
module tb_mem_read_arbiter;

  localparam int N    = 3;
  localparam int MAXO = 2;
  localparam int AW   = 16;
  localparam int DW   = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      m_arvalid, m_arready, m_rvalid, m_rlast, m_rready;
  logic [4*N-1:0]    m_arlen;
  logic [AW*N-1:0]   m_araddr;
  logic [DW-1:0]     m_rdata, s_rdata;
  logic              s_arvalid, s_arready, s_rvalid, s_rlast, s_rready, rid_err;
  logic [3:0]        s_arid, s_arlen, s_rid;
  logic [AW-1:0]     s_araddr;

  always #5 clk = ~clk;

  mem_read_arbiter #(
    .NUM_MASTERS(N), .MAX_OUTSTANDING(MAXO), .ADDR_W(AW), .DATA_W(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arlen(m_arlen), .m_araddr(m_araddr),
    .m_rvalid(m_rvalid), .m_rlast(m_rlast), .m_rready(m_rready), .m_rdata(m_rdata),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_arlen(s_arlen),
    .s_araddr(s_araddr), .s_rvalid(s_rvalid), .s_rlast(s_rlast), .s_rid(s_rid),
    .s_rdata(s_rdata), .s_rready(s_rready), .rid_err(rid_err)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model state (transaction level).
  bit busy;
  int p_id, p_len, p_addr;
  int outst;
  int ptr;
  bit ridm;
  int last_grant;
  bit auto_drop;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    busy  = 1'b0;
    outst = 0;
    ptr   = 0;
    ridm  = 1'b0;
  endtask

  task automatic set_req(input int m, input int len, input int addr);
    m_arvalid[m]          = 1'b1;
    m_arlen[m*4 +: 4]     = 4'(len);
    m_araddr[m*AW +: AW]  = AW'(addr);
  endtask

  // Check one cycle against the model, then advance to the next falling edge.
  task automatic step();
    int g, start, id;
    logic [N-1:0] e_rv, e_rl;
    logic e_srr;
    bit inc, dec;
    #1;
    g     = -1;
    start = 0;
`ifdef READ_ARB_RR_EN
    start = ptr;
`endif
    if (rst_n && !busy && outst < MAXO)
      for (int k = 0; k < N; k++)
        if (g < 0 && m_arvalid[(start + k) % N]) g = (start + k) % N;
    check("m_arready", m_arready, (g >= 0) ? (64'd1 << g) : 64'd0);
    check("s_arvalid", s_arvalid, busy);
    if (busy) begin
      check("s_arid", s_arid, p_id);
      check("s_arlen", s_arlen, p_len);
      check("s_araddr", s_araddr, p_addr);
    end
    id    = int'(s_rid);
    e_rv  = '0;
    e_rl  = '0;
    e_srr = 1'b1;
    if (id < N) begin
      if (s_rvalid) e_rv[id] = 1'b1;
      if (s_rlast)  e_rl[id] = 1'b1;
      e_srr = m_rready[id];
    end
    check("m_rvalid", m_rvalid, e_rv);
    check("m_rlast", m_rlast, e_rl);
    check("s_rready", s_rready, e_srr);
    check("m_rdata", m_rdata, s_rdata);
    check("rid_err", rid_err, ridm);
    if (rst_n) begin
      inc = busy && s_arready;
      dec = s_rvalid && e_srr && s_rlast && (outst > 0);
      if (s_rvalid && id >= N) ridm = 1'b1;
      if (busy) begin
        if (s_arready) busy = 1'b0;
      end else if (g >= 0) begin
        busy   = 1'b1;
        p_id   = g;
        p_len  = int'(m_arlen[g*4 +: 4]);
        p_addr = int'(m_araddr[g*AW +: AW]);
        ptr    = (g + 1) % N;
      end
      outst = outst + int'(inc) - int'(dec);
    end
    last_grant = g;
    @(posedge clk);
    @(negedge clk);
    if (auto_drop && g >= 0) m_arvalid[g] = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int got[$];
    int exp_order[6];
    int n;

    rst_n = 1'b0; m_arvalid = '1; m_arlen = '0; m_araddr = '0; m_rready = '1;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0; s_rid = 4'd0; s_rdata = '0;
    auto_drop = 1'b1;
    model_reset();
    // Reset state, with requests present.
    #2;
    check("rst_arready", m_arready, 3'b000);
    check("rst_arvalid", s_arvalid, 1'b0);
    check("rst_arid", s_arid, 4'd0);
    check("rst_arlen", s_arlen, 4'd0);
    check("rst_araddr", s_araddr, 16'h0);
    check("rst_riderr", rid_err, 1'b0);
    m_arvalid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single master: M1, addr 0x100, len 3.
    set_req(1, 3, 'h100);
    step();
    #1;
    check("sm_arvalid", s_arvalid, 1'b1);
    check("sm_arid", s_arid, 4'd1);
    check("sm_arlen", s_arlen, 4'd3);
    check("sm_araddr", s_araddr, 16'h0100);
    s_arready = 1'b1;
    step();
    s_arready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      s_rvalid = 1'b1; s_rid = 4'd1; s_rlast = (b == 3); s_rdata = DW'($urandom);
      #1;
      check("sm_rvalid", m_rvalid, 3'b010);
      check("sm_rlast", m_rlast, (b == 3) ? 3'b010 : 3'b000);
      step();
    end
    s_rvalid = 1'b0; s_rlast = 1'b0;

    // Contention: all three request continuously.
    do_reset();
    auto_drop = 1'b0;
    set_req(0, 1, 'h10); set_req(1, 2, 'h20); set_req(2, 3, 'h30);
    s_arready = 1'b1;
    s_rid = 4'd0; s_rlast = 1'b1;
    for (int c = 0; c < 60 && got.size() < 6; c++) begin
      s_rvalid = (outst > 0);
      #1;
      for (int j = 0; j < N; j++) if (m_arready[j]) got.push_back(j);
      step();
    end
`ifdef READ_ARB_RR_EN
    exp_order = '{0, 1, 2, 0, 1, 2};
`else
    exp_order = '{0, 0, 0, 0, 0, 0};
`endif
    for (int i = 0; i < 6; i++)
      check("grant_order", (i < got.size()) ? got[i] : 99, exp_order[i]);
    auto_drop = 1'b1;
    m_arvalid = '0; s_rvalid = 1'b0; s_rlast = 1'b0;

    // Outstanding limit: three requests, no returning beats.
    do_reset();
    s_arready = 1'b1;
    set_req(0, 0, 'h1000); set_req(1, 1, 'h2000); set_req(2, 2, 'h3000);
    n = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (|m_arready) n++;
      step();
    end
    check("limit_grants", n, 2);
    #1;
    check("limit_block", m_arready, 3'b000);
    s_rvalid = 1'b1; s_rlast = 1'b1; s_rid = 4'd0;
    step();
    s_rvalid = 1'b0; s_rlast = 1'b0;
    #1;
    check("limit_release", m_arready, 3'b100);
    step();
    // Handshake and last beat in the same cycle: count unchanged at 1.
    s_rvalid = 1'b1; s_rlast = 1'b1; s_rid = 4'd1;
    #1;
    check("simul_hs", s_arvalid, 1'b1);
    step();
    s_rvalid = 1'b0; s_rlast = 1'b0;
    set_req(0, 5, 'h4000);
    #1;
    check("simul_grant", m_arready, 3'b001);
    step();
    step();
    set_req(1, 6, 'h5000);
    n = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (|m_arready) n++;
      step();
    end
    check("simul_full", n, 0);
    s_rvalid = 1'b1; s_rlast = 1'b1; s_rid = 4'd0;
    for (int c = 0; c < 6; c++) step();
    s_rvalid = 1'b0; s_rlast = 1'b0;

    // Backpressure on lane 2.
    s_rvalid = 1'b1; s_rid = 4'd2; m_rready = 3'b011; s_rdata = 16'hBEEF;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("bp_stall", s_rready, 1'b0);
      check("bp_hold", m_rvalid, 3'b100);
      step();
    end
    m_rready = 3'b111;
    #1;
    check("bp_release", s_rready, 1'b1);
    step();

    // Out-of-range ID is sunk and flagged.
    s_rid = 4'd7; m_rready = 3'b000;
    #1;
    check("bad_rready", s_rready, 1'b1);
    check("bad_rvalid", m_rvalid, 3'b000);
    step();
    s_rvalid = 1'b0; m_rready = 3'b111;
    #1;
    check("bad_flag", rid_err, 1'b1);
    step();
    check("bad_sticky", rid_err, 1'b1);

    // Asynchronous reset while in ISSUE.
    s_arready = 1'b0;
    set_req(0, 9, 'h6000);
    step();
    #1;
    check("ar_issue", s_arvalid, 1'b1);
    m_arvalid = '1;
    rst_n = 1'b0;
    #1;
    check("ar_arvalid", s_arvalid, 1'b0);
    check("ar_riderr", rid_err, 1'b0);
    check("ar_arid", s_arid, 4'd0);
    check("ar_arready", m_arready, 3'b000);
    model_reset();
    m_arvalid = '0;
    step();
    rst_n = 1'b1;

    // Randomized traffic.
    for (int c = 0; c < 500; c++) begin
      for (int m = 0; m < N; m++)
        if (!m_arvalid[m] && ($urandom % 3 == 0))
          set_req(m, int'($urandom_range(0, 15)), int'($urandom_range(0, 65535)));
      s_arready = 1'(($urandom % 2) == 0);
      s_rvalid  = 1'(($urandom % 2) == 0);
      s_rlast   = 1'(($urandom % 2) == 0);
      s_rid     = ($urandom % 10 == 0) ? 4'($urandom_range(3, 15)) : 4'($urandom_range(0, 2));
      s_rdata   = DW'($urandom);
      m_rready  = N'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
